// File: rtl/uart_boot_loader_if.sv
// Wishbone classic-pipelined write port between the boot loader (master)
// and the instruction memory (slave).
interface uart_boot_loader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, sel, addr, data, input ack, stall);
    modport slave  (input cyc, stb, we, sel, addr, data, output ack, stall);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 program loader: receives bytes, packs them little-endian into 32-bit words,
// writes them over Wishbone and releases the CPU reset once WORD_CNT words are acknowledged.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          WORD_CNT     = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   uart_rx,
    uart_boot_loader_if.master     wb,
    output logic                   cpu_rst_o,
    output logic                   boot_done_o,
    output logic                   frame_err_o,
    output logic                   ovf_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(WORD_CNT + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_CNT);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WAIT} wb_state_t;

    logic             rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t        rx_state_r, rx_state_nx;
    logic [CNT_W-1:0] clk_cnt_r, clk_cnt_nx;
    logic [2:0]       bit_cnt_r, bit_cnt_nx;
    logic [7:0]       shift_r, shift_nx;
    logic             byte_valid_r, byte_valid_nx;
    logic             frame_err_r, frame_err_nx;

    logic [1:0]       byte_cnt_r, byte_cnt_nx;
    logic [23:0]      word_buf_r, word_buf_nx;
    wb_state_t        wb_state_r, wb_state_nx;
    logic [IDX_W-1:0] word_idx_r, word_idx_nx;
    logic             cyc_r, cyc_nx, stb_r, stb_nx, we_r, we_nx;
    logic [3:0]       sel_r, sel_nx;
    logic [31:0]      addr_r, addr_nx, data_r, data_nx;
    logic             boot_done_r, boot_done_nx, cpu_rst_r, cpu_rst_nx;
    logic             ovf_err_r, ovf_err_nx;
    logic             take_byte_s, word_done_s, finish_s;

    assign wb.cyc      = cyc_r;
    assign wb.stb      = stb_r;
    assign wb.we       = we_r;
    assign wb.sel      = sel_r;
    assign wb.addr     = addr_r;
    assign wb.data     = data_r;
    assign cpu_rst_o   = cpu_rst_r;
    assign boot_done_o = boot_done_r;
    assign frame_err_o = frame_err_r;
    assign ovf_err_o   = ovf_err_r;

    // Receiver next-state: start validation at mid start bit, then one sample per bit period
    always_comb begin
        rx_state_nx   = rx_state_r;
        clk_cnt_nx    = clk_cnt_r;
        bit_cnt_nx    = bit_cnt_r;
        shift_nx      = shift_r;
        byte_valid_nx = 1'b0;
        frame_err_nx  = frame_err_r;
        case (rx_state_r)
            RX_IDLE: begin
                clk_cnt_nx = '0;
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_nx = RX_START;
                end else begin
                    rx_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (clk_cnt_r == HALF_M1) begin
                    clk_cnt_nx = '0;
                    bit_cnt_nx = 3'd0;
                    if (rx_sync_r) begin
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_state_nx = RX_DATA;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_nx = '0;
                    shift_nx   = {rx_sync_r, shift_r[7:1]};
                    bit_cnt_nx = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        rx_state_nx = RX_STOP;
                    end else begin
                        rx_state_nx = RX_DATA;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_nx = '0;
                    if (rx_sync_r) begin
                        byte_valid_nx = 1'b1;
                        rx_state_nx   = RX_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        rx_state_nx  = RX_BREAK;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt_r + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (rx_sync_r) begin
                    rx_state_nx = RX_IDLE;
                end else begin
                    rx_state_nx = RX_BREAK;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // Packer and Wishbone master next-state; the received byte stays in shift_r until the next frame
    always_comb begin
        byte_cnt_nx  = byte_cnt_r;
        word_buf_nx  = word_buf_r;
        wb_state_nx  = wb_state_r;
        word_idx_nx  = word_idx_r;
        cyc_nx       = cyc_r;
        stb_nx       = stb_r;
        we_nx        = we_r;
        sel_nx       = sel_r;
        addr_nx      = addr_r;
        data_nx      = data_r;
        boot_done_nx = boot_done_r;
        cpu_rst_nx   = cpu_rst_r;
        ovf_err_nx   = ovf_err_r;
        finish_s     = 1'b0;
        take_byte_s  = byte_valid_r && !boot_done_r;
        word_done_s  = take_byte_s && (byte_cnt_r == 2'd3);

        if (take_byte_s) begin
            byte_cnt_nx = byte_cnt_r + 2'd1;
            case (byte_cnt_r)
                2'd0:    word_buf_nx[7:0]   = shift_r;
                2'd1:    word_buf_nx[15:8]  = shift_r;
                2'd2:    word_buf_nx[23:16] = shift_r;
                default: word_buf_nx        = word_buf_r;
            endcase
        end else begin
            byte_cnt_nx = byte_cnt_r;
        end

        case (wb_state_r)
            WB_IDLE: begin
                if (word_done_s) begin
                    wb_state_nx = WB_REQ;
                    cyc_nx      = 1'b1;
                    stb_nx      = 1'b1;
                    we_nx       = 1'b1;
                    sel_nx      = 4'hF;
                    addr_nx     = BASE_ADDR + (32'(word_idx_r) << 2);
                    data_nx     = {shift_r, word_buf_r};
                end else begin
                    wb_state_nx = WB_IDLE;
                end
            end
            WB_REQ: begin
                ovf_err_nx = ovf_err_r | word_done_s;
                if (!wb.stall) begin
                    stb_nx = 1'b0;
                    if (wb.ack) begin
                        finish_s = 1'b1;
                    end else begin
                        wb_state_nx = WB_WAIT;
                    end
                end else begin
                    stb_nx = 1'b1;
                end
            end
            WB_WAIT: begin
                ovf_err_nx = ovf_err_r | word_done_s;
                if (wb.ack) begin
                    finish_s = 1'b1;
                end else begin
                    wb_state_nx = WB_WAIT;
                end
            end
            default: wb_state_nx = WB_IDLE;
        endcase

        if (finish_s) begin
            wb_state_nx = WB_IDLE;
            cyc_nx      = 1'b0;
            we_nx       = 1'b0;
            sel_nx      = 4'h0;
            word_idx_nx = word_idx_r + IDX_W'(1);
            if (word_idx_r + IDX_W'(1) == LAST_IDX) begin
                boot_done_nx = 1'b1;
                cpu_rst_nx   = 1'b0;
            end else begin
                boot_done_nx = boot_done_r;
                cpu_rst_nx   = cpu_rst_r;
            end
        end else begin
            word_idx_nx = word_idx_r;
        end
    end

    // State and output registers; reset discards any partial word and drops cyc at once
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            rx_state_r   <= RX_IDLE;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            byte_cnt_r   <= 2'd0;
            word_buf_r   <= 24'h0;
            wb_state_r   <= WB_IDLE;
            word_idx_r   <= '0;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'h0;
            addr_r       <= BASE_ADDR;
            data_r       <= 32'h0;
            boot_done_r  <= 1'b0;
            cpu_rst_r    <= 1'b1;
            ovf_err_r    <= 1'b0;
        end else begin
            rx_meta_r    <= uart_rx;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            rx_state_r   <= rx_state_nx;
            clk_cnt_r    <= clk_cnt_nx;
            bit_cnt_r    <= bit_cnt_nx;
            shift_r      <= shift_nx;
            byte_valid_r <= byte_valid_nx;
            frame_err_r  <= frame_err_nx;
            byte_cnt_r   <= byte_cnt_nx;
            word_buf_r   <= word_buf_nx;
            wb_state_r   <= wb_state_nx;
            word_idx_r   <= word_idx_nx;
            cyc_r        <= cyc_nx;
            stb_r        <= stb_nx;
            we_r         <= we_nx;
            sel_r        <= sel_nx;
            addr_r       <= addr_nx;
            data_r       <= data_nx;
            boot_done_r  <= boot_done_nx;
            cpu_rst_r    <= cpu_rst_nx;
            ovf_err_r    <= ovf_err_nx;
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: UART byte driver, Wishbone slave with
// programmable stall/ack latency, and a byte-stream reference model feeding a scoreboard.
module tb_uart_boot_loader;
    localparam int          CPB      = 16;
    localparam int          WORD_CNT = 32;
    localparam logic [31:0] BASE     = 32'h0;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic uart_rx;
    logic cpu_rst_o, boot_done_o, frame_err_o, ovf_err_o;

    uart_boot_loader_if wb();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .WORD_CNT(WORD_CNT), .BASE_ADDR(BASE)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .wb(wb),
        .cpu_rst_o(cpu_rst_o), .boot_done_o(boot_done_o),
        .frame_err_o(frame_err_o), .ovf_err_o(ovf_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // reference model: good bytes grouped by four, little-endian, addressed by word count
    logic [7:0]  mdl_bytes[$];
    logic [63:0] exp_q[$];
    int          mdl_idx = 0;

    // slave state and measurements
    int stall_cfg = 0, ack_cfg = 0, stall_left = 0, pending = 0;
    int stb_cycles = 0, last_stb = 0, wr_count = 0, ack_count = 0, unstable = 0;
    int cyc_cycles = 0, acc_mark = 0, last_hold = 0;
    logic in_req = 1'b0, ack_prev = 1'b0;
    logic cyc_after = 1'b0, boot_at_ack = 1'b0, boot_after = 1'b0, cpu_after = 1'b1;
    logic [31:0] hold_addr, hold_data, last_addr, last_data;
    logic [63:0] e;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            wb.stall = 1'b0; wb.ack = 1'b0; pending = 0; in_req = 1'b0; ack_prev = 1'b0;
        end else begin
            if (ack_prev) begin
                cyc_after = wb.cyc; boot_after = boot_done_o; cpu_after = cpu_rst_o;
            end
            ack_prev = 1'b0;
            wb.ack = 1'b0;
            if (wb.cyc) cyc_cycles++;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    wb.ack = 1'b1; ack_count++; ack_prev = 1'b1;
                    boot_at_ack = boot_done_o; last_hold = cyc_cycles - acc_mark;
                end
            end
            if (wb.stb) begin
                if (!in_req) begin
                    in_req = 1'b1; stall_left = stall_cfg; stb_cycles = 0;
                    hold_addr = wb.addr; hold_data = wb.data;
                end
                stb_cycles++;
                if (wb.addr !== hold_addr || wb.data !== hold_data) unstable++;
                if (stall_left > 0) begin
                    wb.stall = 1'b1; stall_left--;
                end else begin
                    wb.stall = 1'b0; in_req = 1'b0; wr_count++;
                    last_addr = wb.addr; last_data = wb.data; last_stb = stb_cycles;
                    acc_mark = cyc_cycles;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write got addr=%h data=%h expected no write", wb.addr, wb.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wb.addr, e[63:32]);
                        check("wr_data", wb.data, e[31:0]);
                        check("wr_sel", 32'(wb.sel), 32'hF);
                        check("wr_we", 32'(wb.we), 32'h1);
                    end
                    if (ack_cfg == 0) begin
                        wb.ack = 1'b1; ack_count++; ack_prev = 1'b1;
                        boot_at_ack = boot_done_o; last_hold = 0;
                    end else begin
                        pending = ack_cfg;
                    end
                end
            end else begin
                wb.stall = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input bit track);
        logic [9:0] frame;
        if (track && stop_ok && mdl_idx < WORD_CNT) begin
            mdl_bytes.push_back(b);
            if (mdl_bytes.size() == 4) begin
                exp_q.push_back({BASE + 32'(mdl_idx) * 32'd4,
                                 mdl_bytes[3], mdl_bytes[2], mdl_bytes[1], mdl_bytes[0]});
                mdl_idx++;
                mdl_bytes.delete();
            end
        end
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge sys_clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit track);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, track);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_count < target && n < 3000) begin
            @(posedge sys_clk); #1; n++;
        end
        check("write_count", 32'(wr_count), 32'(target));
        n = 0;
        while (wb.cyc && n < 3000) begin
            @(posedge sys_clk); #1; n++;
        end
        check("cyc_released", 32'(wb.cyc), 32'h0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        mdl_bytes.delete(); exp_q.delete(); mdl_idx = 0;
        wr_count = 0; ack_count = 0;
        @(negedge sys_clk);
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          stall, ack_dly;
        logic [31:0] exp_data, exp_addr;
        int          exp_stb;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int   n;
        int   marks;
        logic [31:0] w;

        vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 5, 0, 32'hDEADBEEF, 32'h4,  6};
        vecs[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 1, 32'h04030201, 32'h8,  1};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 2, 2, 32'h00FF00FF, 32'hC,  3};
        vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 1, 4, 32'h3CC35AA5, 32'h10, 2};

        uart_rx = 1'b1;
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_cyc", 32'(wb.cyc), 32'h0);
        check("rst_stb", 32'(wb.stb), 32'h0);
        check("rst_we", 32'(wb.we), 32'h0);
        check("rst_sel", 32'(wb.sel), 32'h0);
        check("rst_addr", wb.addr, BASE);
        check("rst_data", wb.data, 32'h0);
        check("rst_cpu_rst", 32'(cpu_rst_o), 32'h1);
        check("rst_boot_done", 32'(boot_done_o), 32'h0);
        check("rst_errs", {30'h0, frame_err_o, ovf_err_o}, 32'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // single word, cyc must stay up through the ack wait
        ack_cfg = 3;
        send_byte(8'h13, 1'b1, 1'b1); send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1); send_byte(8'h00, 1'b1, 1'b1);
        wait_writes(1);
        check("first_addr", last_addr, 32'h0);
        check("first_data", last_data, 32'h00000013);
        check("cyc_hold_until_ack", 32'(last_hold), 32'd3);
        check("cyc_drop_after_ack", 32'(cyc_after), 32'h0);

        for (int i = 0; i < 4; i++) begin
            stall_cfg = vecs[i].stall;
            ack_cfg   = vecs[i].ack_dly;
            send_byte(vecs[i].b0, 1'b1, 1'b1); send_byte(vecs[i].b1, 1'b1, 1'b1);
            send_byte(vecs[i].b2, 1'b1, 1'b1); send_byte(vecs[i].b3, 1'b1, 1'b1);
            wait_writes(i + 2);
            check("vec_addr", last_addr, vecs[i].exp_addr);
            check("vec_data", last_data, vecs[i].exp_data);
            check("vec_stb_cycles", 32'(last_stb), 32'(vecs[i].exp_stb));
            check("vec_hold", 32'(last_hold), 32'(vecs[i].ack_dly));
        end
        check("stall_stability", 32'(unstable), 32'h0);

        for (int i = 0; i < 6; i++) begin
            stall_cfg = int'($urandom_range(0, 3));
            ack_cfg   = int'($urandom_range(0, 3));
            send_word($urandom, 1'b1);
            wait_writes(6 + i);
        end
        check("no_errs_yet", {30'h0, frame_err_o, ovf_err_o}, 32'h0);

        // short low glitch on the line must not produce a byte or shift the packer
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge sys_clk);
        check("glitch_no_write", 32'(wr_count), 32'd11);
        check("glitch_no_ferr", 32'(frame_err_o), 32'h0);
        stall_cfg = 0; ack_cfg = 1;
        send_word($urandom, 1'b1);
        wait_writes(12);

        // bad stop bit between bytes 1 and 2
        do_reset();
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h77, 1'b0, 1'b1);
        check("frame_err_set", 32'(frame_err_o), 32'h1);
        send_byte(8'h22, 1'b1, 1'b1); send_byte(8'h33, 1'b1, 1'b1); send_byte(8'h44, 1'b1, 1'b1);
        wait_writes(1);
        check("ferr_word_addr", last_addr, 32'h0);
        check("ferr_word_data", last_data, 32'h44332211);
        check("frame_err_sticky", 32'(frame_err_o), 32'h1);

        // reset after two bytes discards the partial word
        do_reset();
        send_byte(8'hAA, 1'b1, 1'b1); send_byte(8'hBB, 1'b1, 1'b1);
        do_reset();
        check("rst_mid_cyc", 32'(wb.cyc), 32'h0);
        check("rst_mid_cpu_rst", 32'(cpu_rst_o), 32'h1);
        check("rst_mid_ferr", 32'(frame_err_o), 32'h0);
        send_word(32'hCAFE0123, 1'b1);
        wait_writes(1);
        check("rst_word_addr", last_addr, 32'h0);
        check("rst_word_data", last_data, 32'hCAFE0123);

        // word completing during an outstanding write is dropped
        ack_cfg = 900;
        send_word(32'h12345678, 1'b1);
        send_word(32'h0BADF00D, 1'b0);
        check("ovf_set", 32'(ovf_err_o), 32'h1);
        check("ovf_no_extra_write", 32'(wr_count), 32'd2);
        n = 0;
        while (ack_count < 2 && n < 2000) begin
            @(posedge sys_clk); #1; n++;
        end
        check("ovf_ack_seen", 32'(ack_count), 32'd2);
        ack_cfg = 0;
        send_word(32'h55AA33CC, 1'b1);
        wait_writes(3);
        check("ovf_next_addr", last_addr, 32'h8);

        // asynchronous reset while a write waits for ack
        ack_cfg = 500;
        send_word(32'h0F0F0F0F, 1'b1);
        check("pre_rst_cyc", 32'(wb.cyc), 32'h1);
        #2 sys_rst = 1'b1;
        #1 check("async_rst_cyc", 32'(wb.cyc), 32'h0);
        do_reset();
        ack_cfg = 0;

        // full load and boot
        for (int k = 0; k < WORD_CNT; k++) begin
            if (k == WORD_CNT - 1) begin
                check("no_early_boot", 32'(boot_done_o), 32'h0);
                check("no_early_cpu_release", 32'(cpu_rst_o), 32'h1);
            end
            stall_cfg = int'($urandom_range(0, 2));
            ack_cfg   = int'($urandom_range(0, 2));
            w = 32'(k) * 32'd17;
            send_word(w, 1'b1);
            wait_writes(k + 1);
        end
        check("boot_last_addr", last_addr, 32'h7C);
        check("boot_at_ack", 32'(boot_at_ack), 32'h0);
        check("boot_after_ack", 32'(boot_after), 32'h1);
        check("cpu_rst_after_ack", 32'(cpu_after), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        marks = cyc_cycles;
        send_byte(8'h55, 1'b1, 1'b1);
        repeat (50) @(negedge sys_clk);
        check("post_boot_no_cyc", 32'(cyc_cycles - marks), 32'h0);
        check("post_boot_writes", 32'(wr_count), 32'(WORD_CNT));
        check("boot_done_hold", 32'(boot_done_o), 32'h1);
        check("cpu_rst_hold", 32'(cpu_rst_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
